// File: rtl/btn_code_lock.sv
`default_nettype none
// ============================================================================
//  Module      : btn_code_lock
//  Description : Four-button combination lock. Raw buttons are synchronised
//                and debounced, rising edges of the debounced levels act as
//                digit presses, and an FSM walks IDLE->GOT1->GOT2->GOT3->OPEN
//                on the correct code, dropping into a timed FAIL otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_code_lock #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FAIL_CYCLES     = 8,
  parameter logic [7:0]  CODE            = 8'b11_10_01_00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  input  logic [1:0] sw,
  output logic [3:0] led,
  output logic       unlocked,
  output logic       error
);

  // Counter widths sized so the terminal values DEBOUNCE_CYCLES-1 and
  // FAIL_CYCLES-1 always fit (2^16 needs exactly 16 bits).
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned FC_W = (FAIL_CYCLES > 1) ? $clog2(FAIL_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FC_W-1:0] FAIL_LAST = FC_W'(FAIL_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GOT1 = 3'd1,
    GOT2 = 3'd2,
    GOT3 = 3'd3,
    OPEN = 3'd4,
    FAIL = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer
  // --------------------------------------------------------------------------
  logic [3:0] s1_q, s1_d;
  logic [3:0] s2_q, s2_d;

  // Next values of the synchronizer chain.
  always_comb begin
    s1_d = btn;
    s2_d = s1_q;
  end

  // Synchronizer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 4'b0000;
      s2_q <= 4'b0000;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // --------------------------------------------------------------------------
  // Per-button debouncer: the stable level only follows s2 once s2 has
  // disagreed with it for DEBOUNCE_CYCLES consecutive edges.
  // --------------------------------------------------------------------------
  logic [3:0] stable;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_debounce
      logic            stable_q, stable_d;
      logic [DB_W-1:0] cnt_q, cnt_d;

      // Count disagreement; commit the new level on the terminal count.
      always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (s2_q[i] != stable_q) begin
          if (cnt_q == DB_LAST) begin
            stable_d = s2_q[i];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // Debouncer registers.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          stable_q <= 1'b0;
          cnt_q    <= '0;
        end else begin
          stable_q <= stable_d;
          cnt_q    <= cnt_d;
        end
      end

      assign stable[i] = stable_q;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Press detection: one-cycle pulse on each debounced rising edge.
  // --------------------------------------------------------------------------
  logic [3:0] stable_prev_q, stable_prev_d;
  logic [3:0] press;

  // Delayed copy of the debounced levels for edge detection.
  always_comb begin
    stable_prev_d = stable;
    press         = stable & ~stable_prev_q;
  end

  // Delayed-level register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable_prev_q <= 4'b0000;
    end else begin
      stable_prev_q <= stable_prev_d;
    end
  end

  // --------------------------------------------------------------------------
  // Lock FSM
  // --------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [FC_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [1:0]      exp_digit;
  logic [3:0]      exp_onehot;
  logic            one_press;
  logic            accept;
  state_t          adv_state;

  // Expected digit for the current progress state and the successor state.
  always_comb begin
    exp_digit = CODE[1:0];
    adv_state = IDLE;
    case (state_q)
      IDLE: begin exp_digit = CODE[1:0]; adv_state = GOT1; end
      GOT1: begin exp_digit = CODE[3:2]; adv_state = GOT2; end
      GOT2: begin exp_digit = CODE[5:4]; adv_state = GOT3; end
      GOT3: begin exp_digit = CODE[7:6]; adv_state = OPEN; end
      default: begin exp_digit = CODE[1:0]; adv_state = IDLE; end
    endcase
    exp_onehot = 4'b0001 << exp_digit;
    one_press  = (press != 4'b0000) && ((press & (press - 4'd1)) == 4'b0000);
    // Presses seen while frozen are dropped on the floor, not held over.
    accept     = (press != 4'b0000) && !sw[1];
  end

  // Next-state logic; the FAIL timer runs independently of the freeze switch.
  always_comb begin
    state_d    = state_q;
    fail_cnt_d = '0;
    case (state_q)
      IDLE, GOT1, GOT2, GOT3: begin
        if (accept) begin
          if (one_press && (press == exp_onehot)) begin
            state_d = adv_state;
          end else begin
            state_d = FAIL;
          end
        end
      end
      OPEN: begin
        // The press that relocks is consumed and not taken as a first digit.
        if (accept) begin
          state_d = IDLE;
        end
      end
      FAIL: begin
        if (fail_cnt_q == FAIL_LAST) begin
          state_d = IDLE;
        end else begin
          fail_cnt_d = fail_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and FAIL-timer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode from the state register; sw[0] only blanks the LEDs.
  // --------------------------------------------------------------------------
  logic [3:0] pattern;

  // Display pattern and status flags.
  always_comb begin
    pattern  = 4'b0000;
    unlocked = 1'b0;
    error    = 1'b0;
    case (state_q)
      GOT1: pattern = 4'b1000;
      GOT2: pattern = 4'b1100;
      GOT3: pattern = 4'b1110;
      OPEN: begin pattern = 4'b1111; unlocked = 1'b1; end
      FAIL: begin pattern = 4'b0101; error = 1'b1; end
      default: pattern = 4'b0000;
    endcase
    led = sw[0] ? pattern : 4'b0000;
  end

endmodule
`default_nettype wire

// File: doc/btn_code_lock.md
BTN_CODE_LOCK -- requirements
Module: btn_code_lock

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive clk cycles an input must differ from its debounced value before that value changes (legal range 2..2^16).
REQ-002 The block SHALL have parameter FAIL_CYCLES, default 8: cycles spent in FAIL before returning to IDLE (legal range 1..2^16).
REQ-003 The block SHALL have parameter CODE, 8 bits, default 8'b11_10_01_00: four 2-bit button indices. Bits [1:0] give the first digit and bits [7:6] give the last.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port btn, input, 4 bits: raw, asynchronous push-buttons, active-high.
REQ-007 Port sw, input, 2 bits: sw[0]=1 enables the LED display; sw[1]=1 freezes code entry.
REQ-008 Port led, output, 4 bits: progress display.
REQ-009 Port unlocked, output, 1 bit: high while the FSM is in OPEN.
REQ-010 Port error, output, 1 bit: high while the FSM is in FAIL.

Function
REQ-011 Each btn bit SHALL pass through a two-flop synchronizer (s1, then s2) before any other logic uses it.
REQ-012 Each bit SHALL have its own debouncer with a stable register and a counter:
- At each edge where s2 differs from stable, the counter increments.
- At the edge where the counter equals DEBOUNCE_CYCLES-1 and s2 still differs, stable takes the value of s2 and the counter clears.
- At any edge where s2 equals stable, the counter clears.
REQ-013 As a consequence of REQ-012, any s2 pulse shorter than DEBOUNCE_CYCLES cycles SHALL have no effect.
REQ-014 The per-bit press event SHALL be stable & ~stable_d, where stable_d is stable registered one cycle. A press event is one cycle wide; release events are not used.
REQ-015 FSM states SHALL be IDLE, GOT1, GOT2, GOT3, OPEN and FAIL.
REQ-016 The FSM SHALL update only at an edge where exactly one or more press events are high and sw[1]=0. Press events arriving while sw[1]=1 SHALL be discarded, not queued.
REQ-017 In IDLE, GOT1, GOT2 and GOT3, the FSM SHALL transition as follows:
- Exactly one press, matching the expected digit: advance to the next state (GOT3 advances to OPEN).
- Exactly one press, not matching the expected digit: go to FAIL.
- Two or more simultaneous presses: go to FAIL.
REQ-018 In OPEN, any press SHALL return the FSM to IDLE and that press SHALL be consumed, not counted as a first digit.
REQ-019 In FAIL, a cycle counter SHALL run and all presses SHALL be ignored. The FSM SHALL return to IDLE at the edge where FAIL has been occupied for FAIL_CYCLES cycles. The counter SHALL run regardless of sw[1].
REQ-020 The internal display pattern SHALL be: IDLE 0000, GOT1 1000, GOT2 1100, GOT3 1110, OPEN 1111, FAIL 0101.
REQ-021 led SHALL equal the display pattern when sw[0]=1 and 0000 when sw[0]=0. sw[0] SHALL have no effect on the FSM, unlocked or error.
REQ-022 led, unlocked and error SHALL be combinational decodes of the state register only.
REQ-023 An unreachable state encoding SHALL go to IDLE at the next edge.
REQ-024 Latency SHALL be as follows, counting the first edge that samples btn=1 as edge 1:
- s2 is 1 after edge 2.
- stable rises at edge 2+DEBOUNCE_CYCLES.
- State and led change at edge 3+DEBOUNCE_CYCLES (edge 7 for the default).

Reset
REQ-025 When rst_n=0 at a rising edge, all of the following SHALL clear at that edge:
- state to IDLE;
- synchronizers, stable, stable_d, debounce counters and FAIL counter to 0.
REQ-026 While in reset, outputs SHALL read led=0000, unlocked=0, error=0.
REQ-027 Reset SHALL take priority over every other event, including a reset asserted mid-debounce or mid-FAIL.
REQ-028 A button held through reset release SHALL register as a press after DEBOUNCE_CYCLES, per REQ-012.

Verification
REQ-029 Correct code, defaults, sw=01: press btn0, btn1, btn2, btn3 in turn, each held 10 cycles with 10 idle cycles between. Required response:
- led steps 1000, 1100, 1110, 1111;
- the first change occurs exactly at edge 7 of the first press;
- unlocked=1 after the fourth press.
REQ-030 Wrong digit and recovery:
- Stimulus: btn0, then btn2.
- Response: error=1 and led=0101 for exactly 8 cycles, then IDLE with led=0000.
- A press during FAIL has no effect.
REQ-031 Glitch and simultaneous press:
- A 3-cycle btn0 pulse leaves led=0000.
- Pressing btn0 and btn1 together from IDLE gives FAIL.
REQ-032 Freeze and blank:
- In GOT2 with sw[1]=1, pressing btn2 leaves led=1100.
- Then sw[1]=0 and a btn2 press gives 1110.
- Setting sw[0]=0 blanks led to 0000 while the state is held.
REQ-033 Reset mid-operation: drive rst_n=0 for one edge while in GOT3, while in FAIL and during a debounce count. Each time, required response: led=0000, unlocked=0, error=0 at the next edge, and the next correct sequence unlocks normally.
REQ-034 OPEN exit: in OPEN, press btn3, giving IDLE. The full code is then required again to unlock.
